// File: rtl/mult4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult4_pkg
// Brief    : Shared constants and state encoding for the 4x4 shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package mult4_pkg;

    // Operand width; the step adder is a fixed 4-bit ripple-carry adder.
    localparam int unsigned W     = 4;
    localparam int unsigned STEPS = 4;
    localparam int unsigned CNT_W = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mult4_pkg
`default_nettype wire

// File: rtl/rca_4bit.sv
`default_nettype none
// ============================================================================
// Module   : RCA_4bit
// Brief    : 4-bit ripple-carry adder built from a chain of full adders.
// Revision : 1.0 - initial release
// ============================================================================
module RCA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cout = w_carry[4];

endmodule : RCA_4bit
`default_nettype wire

// File: rtl/shift_add_mult4.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mult4
// Brief    : Sequential 4x4 unsigned shift-and-add multiplier, valid/ready I/O.
//            Define MULT4_ZERO_BYPASS_EN to skip the RUN steps for zero operands.
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_mult4
    import mult4_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product
);

    state_t             state_q, state_d;
    logic [W-1:0]       mcand_q, mcand_d;
    logic [W-1:0]       acc_q,   acc_d;
    logic [W-1:0]       mq_q,    mq_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [W-1:0]       w_addend;
    logic [W-1:0]       w_sum;
    logic               w_cout;

    // The multiplier LSB selects whether this step adds the multiplicand.
    assign w_addend = mq_q[0] ? mcand_q : '0;

    RCA_4bit u_step_adder (
        .a    (acc_q),
        .b    (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        cnt_d     = cnt_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    mq_d    = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef MULT4_ZERO_BYPASS_EN
                    if ((a == '0) || (b == '0)) begin
                        mq_d    = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                // {carry,sum,mq} shifted right by one: the consumed multiplier
                // bit drops out and the sum LSB enters the low half.
                acc_d = {w_cout, w_sum[W-1:1]};
                mq_d  = {w_sum[0], mq_q[W-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign product = {acc_q, mq_q};

endmodule : shift_add_mult4
`default_nettype wire
